// File: rtl/hough_pkg.sv
// Shared constants, types and Q1.14 trig constants for the Hough rho front end.
package hough_pkg;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned FRAC    = 14;
    localparam int unsigned N_THETA = 180;
    localparam int unsigned RHO_W   = 16;
    localparam int unsigned THETA_W = 8;
    localparam int unsigned TRIG_W  = 16;
    localparam int unsigned SUM_W   = COORD_W + 17;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef logic signed [TRIG_W-1:0] trig_t;

    typedef struct packed {
        trig_t cos_v;
        trig_t sin_v;
    } trig_pair_t;

    // round(2^14 * sin(k deg)) for k = 0..90; the other quadrants are folded onto it.
    localparam trig_t SIN_Q [91] = '{
        16'sd0,     16'sd286,   16'sd572,   16'sd857,   16'sd1143,
        16'sd1428,  16'sd1713,  16'sd1997,  16'sd2280,  16'sd2563,
        16'sd2845,  16'sd3126,  16'sd3406,  16'sd3686,  16'sd3964,
        16'sd4240,  16'sd4516,  16'sd4790,  16'sd5063,  16'sd5334,
        16'sd5604,  16'sd5872,  16'sd6138,  16'sd6402,  16'sd6664,
        16'sd6924,  16'sd7182,  16'sd7438,  16'sd7692,  16'sd7943,
        16'sd8192,  16'sd8438,  16'sd8682,  16'sd8923,  16'sd9162,
        16'sd9397,  16'sd9630,  16'sd9860,  16'sd10087, 16'sd10311,
        16'sd10531, 16'sd10749, 16'sd10963, 16'sd11174, 16'sd11381,
        16'sd11585, 16'sd11786, 16'sd11982, 16'sd12176, 16'sd12365,
        16'sd12551, 16'sd12733, 16'sd12911, 16'sd13085, 16'sd13255,
        16'sd13421, 16'sd13583, 16'sd13741, 16'sd13894, 16'sd14044,
        16'sd14189, 16'sd14330, 16'sd14466, 16'sd14598, 16'sd14726,
        16'sd14849, 16'sd14968, 16'sd15082, 16'sd15191, 16'sd15296,
        16'sd15396, 16'sd15491, 16'sd15582, 16'sd15668, 16'sd15749,
        16'sd15826, 16'sd15897, 16'sd15964, 16'sd16026, 16'sd16083,
        16'sd16135, 16'sd16182, 16'sd16225, 16'sd16262, 16'sd16294,
        16'sd16322, 16'sd16344, 16'sd16362, 16'sd16374, 16'sd16382,
        16'sd16384
    };

    function automatic trig_t sin_quarter(input logic [6:0] k);
        if (k > 7'd90) begin
            return 16'sd0;
        end
        return SIN_Q[k];
    endfunction

    function automatic trig_t trig_sin(input logic [THETA_W-1:0] t);
        if (t <= THETA_W'(90)) begin
            return sin_quarter(7'(t));
        end
        return sin_quarter(7'(THETA_W'(180) - t));
    endfunction

    function automatic trig_t trig_cos(input logic [THETA_W-1:0] t);
        if (t <= THETA_W'(90)) begin
            return sin_quarter(7'(THETA_W'(90) - t));
        end
        return -sin_quarter(7'(t - THETA_W'(90)));
    endfunction

endpackage

// File: rtl/hough_rho_calc_trig_lut.sv
// Combinational ROM: theta index (degrees) to Q1.14 {cos, sin}.
module hough_trig_lut
    import hough_pkg::*;
(
    input  logic [THETA_W-1:0] theta,
    output trig_pair_t         trig_c
);

    always_comb begin
        trig_c.cos_v = trig_cos(theta);
        trig_c.sin_v = trig_sin(theta);
    end

endmodule

// File: rtl/hough_rho_calc.sv
// Per-pixel Hough front end: sweeps theta 0..N_THETA-1 and streams floor(x*cos + y*sin) >> FRAC.
module hough_rho_calc
    import hough_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [COORD_W-1:0]      in_x,
    input  logic [COORD_W-1:0]      in_y,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [THETA_W-1:0]      out_theta,
    output logic signed [RHO_W-1:0] out_rho,
    output logic                    out_last,
    output logic                    busy
);

    localparam logic [THETA_W-1:0] THETA_LAST = THETA_W'(N_THETA - 1);

    state_e                    state_q, state_d;
    logic [THETA_W-1:0]        theta_q, theta_d;
    logic [COORD_W-1:0]        x_q, x_d, y_q, y_d;
    logic                      v1_q, v1_d;
    logic [THETA_W-1:0]        theta1_q, theta1_d;
    trig_pair_t                trig1_q, trig1_d;
    logic                      v2_q, v2_d;
    logic [THETA_W-1:0]        theta2_q, theta2_d;
    logic signed [SUM_W-1:0]   sum2_q, sum2_d;
    logic                      out_valid_q, out_valid_d;
    logic [THETA_W-1:0]        out_theta_q, out_theta_d;
    logic signed [RHO_W-1:0]   out_rho_q, out_rho_d;
    logic                      out_last_q, out_last_d;
    logic                      in_ready_q, in_ready_d;
    logic                      busy_q, busy_d;

    logic                      advance_c;
    logic                      accept_c;
    logic                      issue_c;
    logic [THETA_W-1:0]        issue_theta_c;
    trig_pair_t                lut_c;
    logic signed [SUM_W-1:0]   x_ext_c, y_ext_c, cos_ext_c, sin_ext_c;

    // Index 0 is issued in the accept cycle itself; theta_q holds the next index to issue.
    assign advance_c     = !out_valid_q | out_ready;
    assign accept_c      = (state_q == IDLE) & in_valid & in_ready_q;
    assign issue_c       = accept_c | ((state_q == SWEEP) & advance_c);
    assign issue_theta_c = (state_q == SWEEP) ? theta_q : '0;

    hough_trig_lut u_lut (
        .theta  (issue_theta_c),
        .trig_c (lut_c)
    );

    always_comb begin
        x_ext_c   = SUM_W'(x_q);
        y_ext_c   = SUM_W'(y_q);
        cos_ext_c = SUM_W'($signed(trig1_q.cos_v));
        sin_ext_c = SUM_W'($signed(trig1_q.sin_v));
    end

    always_comb begin
        state_d     = state_q;
        theta_d     = theta_q;
        x_d         = x_q;
        y_d         = y_q;
        v1_d        = v1_q;
        theta1_d    = theta1_q;
        trig1_d     = trig1_q;
        v2_d        = v2_q;
        theta2_d    = theta2_q;
        sum2_d      = sum2_q;
        out_valid_d = out_valid_q;
        out_theta_d = out_theta_q;
        out_rho_d   = out_rho_q;
        out_last_d  = out_last_q;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    x_d     = in_x;
                    y_d     = in_y;
                    theta_d = THETA_W'(1);
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                if (advance_c) begin
                    theta_d = theta_q + THETA_W'(1);
                    if (theta_q == THETA_LAST) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_valid_q & out_ready & out_last_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Whole pipeline moves together so a stalled output never loses or repeats a result.
        if (advance_c) begin
            v1_d        = issue_c;
            theta1_d    = issue_theta_c;
            trig1_d     = lut_c;
            v2_d        = v1_q;
            theta2_d    = theta1_q;
            sum2_d      = (x_ext_c * cos_ext_c) + (y_ext_c * sin_ext_c);
            out_valid_d = v2_q;
            out_theta_d = theta2_q;
            out_rho_d   = RHO_W'(sum2_q >>> FRAC);
            out_last_d  = v2_q & (theta2_q == THETA_LAST);
        end

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            theta_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            v1_q        <= 1'b0;
            theta1_q    <= '0;
            trig1_q     <= '0;
            v2_q        <= 1'b0;
            theta2_q    <= '0;
            sum2_q      <= '0;
            out_valid_q <= 1'b0;
            out_theta_q <= '0;
            out_rho_q   <= '0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            theta_q     <= theta_d;
            x_q         <= x_d;
            y_q         <= y_d;
            v1_q        <= v1_d;
            theta1_q    <= theta1_d;
            trig1_q     <= trig1_d;
            v2_q        <= v2_d;
            theta2_q    <= theta2_d;
            sum2_q      <= sum2_d;
            out_valid_q <= out_valid_d;
            out_theta_q <= out_theta_d;
            out_rho_q   <= out_rho_d;
            out_last_q  <= out_last_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_theta = out_theta_q;
    assign out_rho   = out_rho_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

endmodule

// File: doc/hough_rho_calc.md
Name: hough_rho_calc

Overview:
- Per-pixel Hough voting front end for lane detection.
- Accepts one edge-pixel coordinate (x, y) through a valid/ready handshake.
- Sweeps theta index 0..N_THETA-1 and emits one signed rho = floor((x*cos(theta) + y*sin(theta)) / 2^FRAC) per theta.
- Sits directly upstream of the 16-bit add/sub accumulator-update datapath, which consumes (theta, rho) to address and increment vote bins.

Parameters:
- COORD_W, 10, unsigned pixel coordinate width (x, y).
- FRAC, 14, fractional bits of the signed trig constants (Q1.14, 16-bit signed).
- N_THETA, 180, number of theta steps; 1 degree per step, theta index t means t degrees.
- RHO_W, 16, signed rho output width (matches downstream 16-bit adder).
- THETA_W, 8, theta index width; must satisfy 2^THETA_W >= N_THETA.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  pixel coordinate valid.
- in_ready  output  1  block can accept a pixel.
- in_x  input  COORD_W  pixel column, unsigned.
- in_y  input  COORD_W  pixel row, unsigned.
- out_valid  output  1  rho/theta result valid.
- out_ready  input  1  downstream accepts the result.
- out_theta  output  THETA_W  theta index of the result.
- out_rho  output  RHO_W  signed rho, two's complement.
- out_last  output  1  high with the result for theta = N_THETA-1.
- busy  output  1  sweep in progress or results pending.

Behaviour:
- Reset, asynchronous and active-high: FSM goes to IDLE, theta counter = 0, all pipeline valids = 0. Output values on reset: in_ready=1, out_valid=0, out_theta=0, out_rho=0, out_last=0, busy=0.
- FSM states:
  - IDLE: in_ready=1. When in_valid is high, x and y are latched, the theta counter is cleared, and the FSM moves to SWEEP.
  - SWEEP: in_ready=0. One theta index is issued per advancing cycle. After index N_THETA-1 is issued, the FSM moves to DRAIN.
  - DRAIN: in_ready=0. The FSM waits until the pipeline is empty, meaning the last result has handshaked (out_valid & out_ready), then returns to IDLE.
- A new pixel is never accepted in the same cycle the last result leaves; the earliest acceptance is the following cycle.
- Pipeline:
  - Stage 1: LUT lookup of cos/sin for the issued theta, registered.
  - Stage 2: products x*cos and y*sin, signed sum at full width (COORD_W+17 bits), registered.
  - Stage 3: output register holding the arithmetic right shift by FRAC (floor toward negative infinity), truncated to RHO_W.
- Latency: the first result has out_valid high 3 cycles after the in_valid & in_ready handshake cycle.
- With out_ready held high, throughput is one result per cycle, so N_THETA consecutive results.
- Backpressure: the whole pipeline, including the theta counter, advances only when advance = !out_valid | out_ready.
- While out_valid=1 and out_ready=0, out_theta, out_rho and out_last hold stable, and no result is dropped or duplicated.
- Results appear in strictly increasing theta order, 0..N_THETA-1. out_last is high only on theta = N_THETA-1.
- Range: |rho| <= sqrt(2)*(2^COORD_W - 1) < 2^15, so no saturation is needed at the default widths.
- busy = (state != IDLE).
- in_x and in_y are sampled only at the handshake; changes during a sweep are ignored.
- Reset asserted mid-sweep aborts the sweep immediately. No further outputs appear, and in_ready=1 on the first cycle after reset deasserts.

Decomposition:
- Shared package hough_pkg holds:
  - constants: FRAC, N_THETA, RHO_W, THETA_W, TRIG_W=16;
  - state typedef: IDLE, SWEEP, DRAIN;
  - function trig_cos(t) / trig_sin(t), giving round(2^FRAC * cos/sin(t degrees)) as signed 16-bit.
- One sub-module, hough_trig_lut: a combinational ROM from theta index to {cos, sin}, built from the package functions. The registered LUT output stage stays in hough_rho_calc.

Test Plan:
- Reset, then x=100, y=50 with out_ready=1:
  - first out_valid 3 cycles after the handshake;
  - 180 consecutive results;
  - theta 0 gives rho=100; theta 90 gives rho=50;
  - theta 45 (cos=sin=11585) gives rho=106; theta 135 gives rho=-36;
  - out_last only on theta 179;
  - in_ready returns to 1 after the last handshake.
- Same pixel with out_ready toggling on a pseudo-random pattern: exactly 180 results, theta strictly 0..179 with no gaps or repeats, and output held stable while stalled.
- Corner pixels (0,0), (1023,0), (0,1023) and (1023,1023): every rho matches a floor-based reference model. Pixel (0,0) gives rho=0 for all theta.
- in_valid held high continuously for two pixels A=(10,20) and B=(300,5): B is accepted only after A's 180th result handshakes, and B's results follow A's with no interleaving.
- Reset pulsed at theta=60 mid-sweep with out_ready=1:
  - out_valid=0 immediately;
  - in_ready=1 after release;
  - a new pixel (7,7) then produces a fresh theta 0 result, rho=7.
- in_x/in_y changed during the sweep: rho values still correspond to the latched coordinates.
